// File: rtl/gtx_align_pkg.sv
// rtl/gtx_align_pkg.sv - shared constants and FSM encoding for the GTX word aligner
package gtx_align_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } align_state_t;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [15:0] IDLE_WORD = 16'h50BC;

endpackage

// File: rtl/gtx_rx_word_align_if.sv
// rtl/gtx_rx_word_align_if.sv - raw receive input and aligned output bundle of one lane
interface gtx_rx_word_align_if;
    logic [15:0] rx_data_in;
    logic [1:0]  rx_char_in;
    logic [15:0] rx_data;
    logic [1:0]  rx_char;
    logic        rx_valid;
    logic        aligned;
    logic        byte_sel;
    logic [7:0]  realign_cnt;

    modport master (
        output rx_data_in, rx_char_in,
        input  rx_data, rx_char, rx_valid, aligned, byte_sel, realign_cnt
    );

    modport slave (
        input  rx_data_in, rx_char_in,
        output rx_data, rx_char, rx_valid, aligned, byte_sel, realign_cnt
    );
endinterface

// File: rtl/gtx_comma_det.sv
// rtl/gtx_comma_det.sv - combinational comma lane detector for a 2-byte word
module gtx_comma_det
    import gtx_align_pkg::*;
#(
    parameter logic [7:0] COMMA = K28_5
) (
    input  logic [15:0] data,
    input  logic [1:0]  k_flags,
    output logic        comma,
    output logic        pos
);
    logic c0;
    logic c1;

    assign c0 = k_flags[0] & (data[7:0]  == COMMA);
    assign c1 = k_flags[1] & (data[15:8] == COMMA);

    // A comma in both lanes is ambiguous, so it is not reported at all.
    assign comma = c0 ^ c1;
    assign pos   = c1;
endmodule

// File: rtl/gtx_rx_word_align.sv
// rtl/gtx_rx_word_align.sv - per-lane 16-bit comma word aligner with lock FSM
module gtx_rx_word_align
    import gtx_align_pkg::*;
#(
    parameter logic [7:0]  COMMA    = K28_5,
    parameter int          LOCK_CNT = 4,
    parameter int          LOSS_CNT = 4,
    parameter logic [15:0] IDLE     = IDLE_WORD
) (
    input logic                usrclk,
    input logic                usrrst,
    gtx_rx_word_align_if.slave bus
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    align_state_t state;
    align_state_t state_n;
    logic         byte_sel_q;
    logic         byte_sel_n;
    logic [3:0]   good_cnt;
    logic [3:0]   good_n;
    logic [3:0]   miss_cnt;
    logic [3:0]   miss_n;
    logic [7:0]   realign_q;
    logic [7:0]   realign_n;
    logic [15:0]  prev_data;
    logic [1:0]   prev_char;
    logic [15:0]  shift_data;
    logic [1:0]   shift_char;
    logic [15:0]  data_q;
    logic [1:0]   char_q;
    logic         valid_q;
    logic         comma;
    logic         pos;

    gtx_comma_det #(.COMMA(COMMA)) u_comma_det (
        .data    (bus.rx_data_in),
        .k_flags (bus.rx_char_in),
        .comma   (comma),
        .pos     (pos)
    );

    // Shifted lane pairs the held high byte with the newest low byte, keeping latency at 2.
    always_comb begin
        shift_data = prev_data;
        shift_char = prev_char;
        if (byte_sel_q) begin
            shift_data = {bus.rx_data_in[7:0], prev_data[15:8]};
            shift_char = {bus.rx_char_in[0], prev_char[1]};
        end
    end

    always_comb begin
        state_n    = state;
        byte_sel_n = byte_sel_q;
        good_n     = good_cnt;
        miss_n     = miss_cnt;
        realign_n  = realign_q;
        if (comma) begin
            case (state)
                HUNT: begin
                    byte_sel_n = pos;
                    good_n     = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_n = LOCK;
                        miss_n  = 4'd0;
                    end else begin
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (pos == byte_sel_q) begin
                        good_n = good_cnt + 4'd1;
                        if (good_n == LOCK_N) begin
                            state_n = LOCK;
                            miss_n  = 4'd0;
                        end
                    end else begin
                        byte_sel_n = pos;
                        good_n     = 4'd1;
                    end
                end
                LOCK: begin
                    if (pos == byte_sel_q) begin
                        miss_n = 4'd0;
                    end else begin
                        miss_n = miss_cnt + 4'd1;
                        if (miss_n == LOSS_N) begin
                            state_n = HUNT;
                            good_n  = 4'd0;
                            miss_n  = 4'd0;
                            if (realign_q != 8'hFF) begin
                                realign_n = realign_q + 8'd1;
                            end
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge usrclk) begin
        if (usrrst) begin
            state      <= HUNT;
            byte_sel_q <= 1'b0;
            good_cnt   <= 4'd0;
            miss_cnt   <= 4'd0;
            realign_q  <= 8'd0;
            prev_data  <= 16'd0;
            prev_char  <= 2'd0;
            data_q     <= IDLE;
            char_q     <= 2'b01;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_n;
            byte_sel_q <= byte_sel_n;
            good_cnt   <= good_n;
            miss_cnt   <= miss_n;
            realign_q  <= realign_n;
            prev_data  <= bus.rx_data_in;
            prev_char  <= bus.rx_char_in;
            valid_q    <= (state == LOCK);
            data_q     <= (state == LOCK) ? shift_data : IDLE;
            char_q     <= (state == LOCK) ? shift_char : 2'b01;
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_char     = char_q;
    assign bus.rx_valid    = valid_q;
    assign bus.aligned     = valid_q;
    assign bus.byte_sel    = byte_sel_q;
    assign bus.realign_cnt = realign_q;
endmodule
